pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, meaning extra data-RAM wait cycles per MEM-stage access (legal 0..3).
REQ-002 SHALL have port CLK, in, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, in, 1, reset; synchronous and active-high.
REQ-004 SHALL have ports idRx and idRy, in, 3 each, source register numbers of the instruction in ID.
REQ-005 SHALL have ports idUseRx and idUseRy, in, 1 each, high when the ID instruction reads that source.
REQ-006 SHALL have ports exMemRead, exRegWrite, exDstReg, in, 1/1/3, load flag, write flag and destination of the ID/EX instruction.
REQ-007 SHALL have ports exBranchTaken and exJump, in, 1 each, resolved redirect from EX.
REQ-008 SHALL have port memAccess, in, 1, high while EX/MEM holds a load or store using the shared RAM.
REQ-009 SHALL have ports pcWrite, ifIdWrite, idExWrite, exMemWrite, out, 1 each, stage register enables.
REQ-010 SHALL have ports ifIdFlush and idExFlush, out, 1 each; flush loads a NOP on the next edge and overrides the matching write enable.

Function
REQ-011 SHALL hold a registered state RUN or MEMWAIT plus a 2-bit wait counter; all outputs combinational from state, counter and inputs.
REQ-012 SHALL, in RUN with no hazard, drive all write enables 1 and both flushes 0.
REQ-013 SHALL treat loadUse = exMemRead & exRegWrite & ((idUseRx & idRx==exDstReg) | (idUseRy & idRy==exDstReg)).
REQ-014 SHALL treat redirect = exBranchTaken | exJump.
REQ-015 SHALL, in RUN with memAccess and MEM_WAIT>0 (freeze), drive all write enables 0, both flushes 0, load counter with MEM_WAIT and enter MEMWAIT; freeze has highest priority.
REQ-016 SHALL, in MEMWAIT with counter>1, freeze as REQ-015 and decrement the counter.
REQ-017 SHALL, in MEMWAIT with counter==1 (release cycle), evaluate the RUN rules REQ-018..021 with memAccess treated as a completing access, then return to RUN.
REQ-018 SHALL, on redirect (not frozen), drive pcWrite=1, ifIdFlush=1, idExFlush=1, idExWrite=1, exMemWrite=1, ignoring loadUse.
REQ-019 SHALL, on loadUse without redirect, drive pcWrite=0, ifIdWrite=0, ifIdFlush=0, idExFlush=1, exMemWrite=1.
REQ-020 SHALL, on completing access (memAccess with MEM_WAIT=0, or release cycle) without redirect, drive pcWrite=0 and ifIdFlush=1 (no fetch slot); when combined with loadUse, REQ-019 values win for ifIdWrite/ifIdFlush.
REQ-021 SHALL produce a complete access in exactly MEM_WAIT+1 cycles; memAccess still high in the cycle after the release SHALL be taken as a new access.
REQ-022 SHALL ignore redirect and loadUse during freeze cycles; they are re-evaluated on release.

Reset
REQ-023 SHALL, while RST=1, set state RUN, counter 0, and drive all write enables 0, ifIdFlush=1, idExFlush=1.
REQ-024 SHALL, on the first cycle after RST falls with no hazards, drive REQ-012 values; RST mid-MEMWAIT SHALL abort the wait.

Configuration
REQ-025 SHALL, with macro PIPELINE_CTRL_STALL_COUNT_EN defined, add output stallCount, 16 bits, incremented each non-reset cycle with pcWrite=0, saturating at 16'hFFFF, cleared by RST.
REQ-026 SHALL, without PIPELINE_CTRL_STALL_COUNT_EN, omit the port and counter with otherwise identical behaviour.

Verification
REQ-027 SHALL cover load-use: exMemRead=1, exRegWrite=1, exDstReg=3, idRx=3, idUseRx=1 -> one cycle pcWrite=0, ifIdWrite=0, idExFlush=1; next cycle (exMemRead=0) -> all enables 1.
REQ-028 SHALL cover redirect: exBranchTaken=1 with loadUse also true -> pcWrite=1, ifIdFlush=1, idExFlush=1.
REQ-029 SHALL cover MEM_WAIT=2, memAccess held 3 cycles -> 2 freeze cycles (all enables 0), then release cycle pcWrite=0, ifIdFlush=1, exMemWrite=1, state RUN.
REQ-030 SHALL cover MEM_WAIT=0, memAccess=1 -> same cycle pcWrite=0, ifIdFlush=1, idExWrite=1, state stays RUN.
REQ-031 SHALL cover RST=1 in second MEMWAIT cycle -> next cycle state RUN, ifIdFlush=1, idExFlush=1; with macro, stallCount=0.
REQ-032 SHALL cover, with macro, 5 stall cycles from reset -> stallCount=5; forced 16'hFFFF plus a stall -> stays 16'hFFFF.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and memory-wait controller for a 5-stage pipeline: stage enables and flushes.
// Optional stall counter output is enabled by defining PIPELINE_CTRL_STALL_COUNT_EN.
//
// state   | meaning
// RUN     | normal issue; hazards resolved combinationally each cycle
// MEMWAIT | data-RAM access in flight; wait_cnt==1 is the release cycle
module pipeline_ctrl #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] idRx,
    input  logic [2:0] idRy,
    input  logic       idUseRx,
    input  logic       idUseRy,
    input  logic       exMemRead,
    input  logic       exRegWrite,
    input  logic [2:0] exDstReg,
    input  logic       exBranchTaken,
    input  logic       exJump,
    input  logic       memAccess,
    output logic       pcWrite,
    output logic       ifIdWrite,
    output logic       idExWrite,
    output logic       exMemWrite,
    output logic       ifIdFlush,
    output logic       idExFlush
`ifdef PIPELINE_CTRL_STALL_COUNT_EN
    ,
    output logic [15:0] stallCount
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(MEM_WAIT);

    state_t     state;
    logic [1:0] wait_cnt;
    logic       load_use;
    logic       redirect;
    logic       freeze;
    logic       complete;

    always_comb begin
        load_use = exMemRead & exRegWrite &
                   ((idUseRx & (idRx == exDstReg)) | (idUseRy & (idRy == exDstReg)));
        redirect = exBranchTaken | exJump;
        freeze   = 1'b0;
        complete = 1'b0;

        // A zero-wait access completes in the cycle it is presented.
        if (state == RUN) begin
            if (memAccess) begin
                if (MEM_WAIT == 0) complete = 1'b1;
                else               freeze   = 1'b1;
            end
        end else begin
            if (wait_cnt > 2'd1) freeze   = 1'b1;
            else                 complete = 1'b1;
        end

        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        idExWrite  = 1'b1;
        exMemWrite = 1'b1;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;

        if (RST) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
        end else if (freeze) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
        end else if (redirect) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
        end else begin
            if (complete) begin
                pcWrite   = 1'b0;
                ifIdFlush = 1'b1;
            end
            // Load-use holds the IF/ID instruction, so it must not also be flushed.
            if (load_use) begin
                pcWrite   = 1'b0;
                ifIdWrite = 1'b0;
                ifIdFlush = 1'b0;
                idExFlush = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= RUN;
            wait_cnt <= 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (memAccess && (MEM_WAIT != 0)) begin
                        state    <= MEMWAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                MEMWAIT: begin
                    if (wait_cnt > 2'd1) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end else begin
                        state    <= RUN;
                        wait_cnt <= 2'd0;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 2'd0;
                end
            endcase
        end
    end

`ifdef PIPELINE_CTRL_STALL_COUNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= 16'd0;
        end else if (!pcWrite && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stallCount = stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl with MEM_WAIT = 0, 1 and 2 instances in parallel.
module tb_pipeline_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] idRx, idRy, exDstReg;
    logic       idUseRx, idUseRy, exMemRead, exRegWrite;
    logic       exBranchTaken, exJump, memAccess;

    // Output vector order: {pcWrite, ifIdWrite, idExWrite, exMemWrite, ifIdFlush, idExFlush}
    wire [5:0]  obs [3];
    wire [15:0] sc  [3];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipeline_ctrl #(.MEM_WAIT(g)) u_dut (
            .CLK          (CLK),
            .RST          (RST),
            .idRx         (idRx),
            .idRy         (idRy),
            .idUseRx      (idUseRx),
            .idUseRy      (idUseRy),
            .exMemRead    (exMemRead),
            .exRegWrite   (exRegWrite),
            .exDstReg     (exDstReg),
            .exBranchTaken(exBranchTaken),
            .exJump       (exJump),
            .memAccess    (memAccess),
            .pcWrite      (obs[g][5]),
            .ifIdWrite    (obs[g][4]),
            .idExWrite    (obs[g][3]),
            .exMemWrite   (obs[g][2]),
            .ifIdFlush    (obs[g][1]),
            .idExFlush    (obs[g][0])
`ifdef PIPELINE_CTRL_STALL_COUNT_EN
            ,
            .stallCount   (sc[g])
`endif
        );
`ifndef PIPELINE_CTRL_STALL_COUNT_EN
        assign sc[g] = 16'd0;
`endif
    end

    typedef struct {
        string             tag;
        logic [2:0][5:0]   exp;
        logic [2:0][5:0]   mask;
        logic [2:0][15:0]  scnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          acc_k [3];
    logic [15:0] m_sc  [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // acc_k counts elapsed cycles of the current RAM access (-1 = none);
    // an access of width w freezes for cycles 0..w-1 and completes at cycle w.
    task automatic model(input int w, output logic [5:0] e, output logic [5:0] m,
                         output logic [15:0] s);
        bit lu, rd, frz, cmp;
        int k;
        lu = exMemRead && exRegWrite &&
             ((idUseRx && idRx == exDstReg) || (idUseRy && idRy == exDstReg));
        rd = exBranchTaken || exJump;
        s  = m_sc[w];
        m  = 6'b111111;
        frz = 0;
        cmp = 0;
        if (RST) begin
            e        = 6'b000011;
            acc_k[w] = -1;
            m_sc[w]  = 16'd0;
        end else begin
            if (acc_k[w] >= 0 || memAccess) begin
                k = (acc_k[w] >= 0) ? acc_k[w] : 0;
                if (k < w) begin
                    frz      = 1;
                    acc_k[w] = k + 1;
                end else begin
                    cmp      = 1;
                    acc_k[w] = -1;
                end
            end
            if (frz) begin
                e = 6'b000000;
            end else if (rd) begin
                e = 6'b111111;
                m = 6'b101111;
            end else begin
                e = 6'b111100;
                if (cmp) begin e[5] = 1'b0; e[1] = 1'b1; end
                if (lu)  begin e[5] = 1'b0; e[4] = 1'b0; e[1] = 1'b0; e[0] = 1'b1; end
                if (e[1]) m[4] = 1'b0;
                if (e[0]) m[3] = 1'b0;
            end
            if (!e[5] && m_sc[w] != 16'hFFFF) m_sc[w] = m_sc[w] + 16'd1;
        end
    endtask

    task automatic step(input string tag, input bit quiet = 0);
        exp_t        e;
        logic [5:0]  ev, mv;
        logic [15:0] sv;
        e.tag = tag;
        for (int w = 0; w < 3; w++) begin
            model(w, ev, mv, sv);
            e.exp[w]  = ev;
            e.mask[w] = mv;
            e.scnt[w] = sv;
        end
        if (!quiet) sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic clear();
        RST = 0; idRx = 0; idRy = 0; idUseRx = 0; idUseRy = 0;
        exMemRead = 0; exRegWrite = 0; exDstReg = 0;
        exBranchTaken = 0; exJump = 0; memAccess = 0;
    endtask

    task automatic set_load_use();
        exMemRead = 1; exRegWrite = 1; exDstReg = 3; idRx = 3; idUseRx = 1;
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            for (int w = 0; w < 3; w++) begin
                check($sformatf("%s/w%0d", cur.tag, w),
                      32'(obs[w] & cur.mask[w]), 32'(cur.exp[w] & cur.mask[w]));
`ifdef PIPELINE_CTRL_STALL_COUNT_EN
                check($sformatf("%s/w%0d/stall", cur.tag, w), 32'(sc[w]), 32'(cur.scnt[w]));
`endif
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int w = 0; w < 3; w++) begin acc_k[w] = -1; m_sc[w] = 16'd0; end
        clear();
        RST = 1;
        @(posedge CLK);
        #1;
        step("reset0");
        step("reset1");
        clear();
        step("idle0");
        step("idle1");

        set_load_use();                 step("lu_rx");
        exMemRead = 0;                  step("lu_clear");
        clear(); exMemRead = 1; exRegWrite = 1; exDstReg = 5; idRy = 5; idUseRy = 1;
                                        step("lu_ry");
        idUseRy = 0;                    step("lu_ry_unused");
        idUseRy = 1; exRegWrite = 0;    step("lu_nowrite");
        clear(); set_load_use(); idRx = 2; step("lu_mismatch");

        clear(); set_load_use(); exBranchTaken = 1; step("redir_lu");
        clear(); exJump = 1;            step("jump");
        clear();                        step("idle2");

        memAccess = 1;                  step("mem_c0");
                                        step("mem_c1");
                                        step("mem_c2");
        memAccess = 0;                  step("mem_after0");
                                        step("mem_after1");
                                        step("mem_after2");

        memAccess = 1; exBranchTaken = 1; step("mem_redir0");
        memAccess = 0; set_load_use();  step("mem_redir1");
        clear(); set_load_use();        step("mem_redir2");
        clear();                        step("mem_redir3");
                                        step("mem_redir4");

        memAccess = 1;                  step("mw_rst0");
                                        step("mw_rst1");
        RST = 1;                        step("mw_rst2");
        clear();                        step("mw_rst3");

        RST = 1;                        step("sc_rst");
        clear(); set_load_use();
        for (int i = 0; i < 5; i++)     step($sformatf("sc_stall%0d", i));
        clear();                        step("sc_five");

        for (int i = 0; i < 300; i++) begin
            RST           = ($urandom_range(0, 49) == 0);
            idRx          = 3'($urandom_range(0, 7));
            idRy          = 3'($urandom_range(0, 7));
            exDstReg      = 3'($urandom_range(0, 3));
            idUseRx       = 1'($urandom_range(0, 1));
            idUseRy       = 1'($urandom_range(0, 1));
            exMemRead     = 1'($urandom_range(0, 1));
            exRegWrite    = 1'($urandom_range(0, 1));
            exBranchTaken = ($urandom_range(0, 5) == 0);
            exJump        = ($urandom_range(0, 9) == 0);
            memAccess     = ($urandom_range(0, 3) == 0);
            step($sformatf("rand%0d", i));
        end

`ifdef PIPELINE_CTRL_STALL_COUNT_EN
        clear(); RST = 1;               step("sat_rst");
        clear(); set_load_use();
        for (int i = 0; i < 65540; i++) step("sat_run", 1'b1);
                                        step("sat_hold0");
                                        step("sat_hold1");
        clear();                        step("sat_idle");
        RST = 1;                        step("sat_rst2");
        clear();                        step("sat_cleared");
`endif

        clear();
        @(negedge CLK);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
